// File: rtl/rnd_hex_scan.sv
// LFSR random-number source with run/hold/step rate control and an N-digit multiplexed hex scanner.
// All outputs registered, one cycle after their cause; no backpressure. Define RND_HEX_BLANK_EN for leading-zero blanking.
module rnd_hex_scan #(
  parameter int                  DIGITS  = 4,
  parameter int                  CLK_HZ  = 50_000_000,
  parameter int                  UPD_HZ  = 2,
  parameter int                  SCAN_HZ = 1000,
  parameter logic [4*DIGITS-1:0] SEED    = {{(4*DIGITS-1){1'b0}}, 1'b1},
  parameter logic [4*DIGITS-1:0] TAPS    = (4*DIGITS)'(16'hB400)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_mode,
  input  logic                  i_step,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_seed,
  output logic [4*DIGITS-1:0]   o_data,
  output logic                  o_valid,
  output logic [DIGITS-1:0]     o_anodes,
  output logic [7:0]            o_segments
);
  localparam int W   = 4*DIGITS;
  localparam int DIV = CLK_HZ/UPD_HZ;
  localparam int P   = CLK_HZ/(SCAN_HZ*DIGITS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (P > 1) ? $clog2(P) : 1;
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [W-1:0] RST_DATA = (SEED == '0) ? W'(1) : SEED;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b10;

  logic [W-1:0]      data_q, data_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     div_q, div_d;
  logic              step_prev_q;
  logic [PW-1:0]     slot_q;
  logic [DW-1:0]     dig_q;
  logic [DIGITS-1:0] anodes_q;
  logic [7:0]        seg_q;
  logic              tick, step_edge, adv, blank;
  logic [3:0]        nib;
  logic [7:0]        seg_code;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction

  assign tick      = (div_q == CW'(DIV-1));
  assign step_edge = i_step & ~step_prev_q;

  // Load outranks every advance source and restarts the rate divider.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    div_d   = tick ? '0 : div_q + CW'(1);
    adv     = ((i_mode == MODE_RUN) && tick) || ((i_mode == MODE_STEP) && step_edge);
    if (i_load) begin
      data_d  = (i_seed == '0) ? W'(1) : i_seed;
      div_d   = '0;
      valid_d = 1'b1;
    end else if (adv) begin
      data_d  = {data_q[W-2:0], ^(data_q & TAPS)};
      valid_d = 1'b1;
    end
  end

  assign nib      = data_q[4*dig_q +: 4];
  assign seg_code = seg7(nib);

`ifdef RND_HEX_BLANK_EN
  assign blank = (dig_q != '0) && ((data_q >> (4*dig_q)) == '0);
`else
  assign blank = 1'b0;
`endif

  // Slot start blanks all anodes for one cycle and latches the new digit's segments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= RST_DATA;
      valid_q     <= 1'b0;
      div_q       <= '0;
      step_prev_q <= 1'b0;
      slot_q      <= '0;
      dig_q       <= '0;
      anodes_q    <= '1;
      seg_q       <= 8'hFF;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      div_q       <= div_d;
      step_prev_q <= i_step;
      if (slot_q == PW'(P-1)) begin
        slot_q <= '0;
        dig_q  <= (dig_q == DW'(DIGITS-1)) ? '0 : dig_q + DW'(1);
      end else begin
        slot_q <= slot_q + PW'(1);
      end
      if (slot_q == '0) begin
        anodes_q <= '1;
        seg_q    <= blank ? 8'hFF : seg_code;
      end else begin
        anodes_q <= ~(DIGITS'(1) << dig_q);
      end
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_anodes   = anodes_q;
  assign o_segments = seg_q;
endmodule

// File: tb/tb_rnd_hex_scan.sv
// Bench for rnd_hex_scan: behavioural model compared every cycle, plus directed literal checks and random stimulus.
`timescale 1ns/1ps
module tb_rnd_hex_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  i_mode = 2'b00;
  logic        i_step = 1'b0;
  logic        i_load = 1'b0;
  logic [15:0] i_seed = 16'h0000;
  logic [15:0] o_data;
  logic        o_valid;
  logic [3:0]  o_anodes;
  logic [7:0]  o_segments;

  int errors = 0;
  int checks = 0;

`ifdef RND_HEX_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  always #5 clk = ~clk;

  rnd_hex_scan #(.DIGITS(4), .CLK_HZ(1000), .UPD_HZ(100), .SCAN_HZ(50),
                 .SEED(16'h0001), .TAPS(16'hB400)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_step(i_step), .i_load(i_load),
    .i_seed(i_seed), .o_data(o_data), .o_valid(o_valid),
    .o_anodes(o_anodes), .o_segments(o_segments));

  logic [7:0] segtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  // Model: n = clock edges since reset release, hist[n] = value held after that edge.
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_prev;
  logic        m_tick;
  int          m_since;
  int          n;
  logic [15:0] hist [0:4095];

  always @(posedge clk) begin
    if (rst) begin
      m_data  = 16'h0001;
      m_valid = 1'b0;
      m_prev  = 1'b0;
      m_since = 0;
      n       = 0;
      hist[0] = 16'h0001;
    end else begin
      m_tick  = (m_since % 10) == 9;
      m_valid = 1'b0;
      if (i_load) begin
        m_data  = (i_seed == 16'h0) ? 16'h0001 : i_seed;
        m_valid = 1'b1;
        m_since = 0;
      end else begin
        if ((i_mode == 2'b00 && m_tick) || (i_mode == 2'b10 && i_step && !m_prev)) begin
          m_data  = lfsr(m_data);
          m_valid = 1'b1;
        end
        m_since++;
      end
      m_prev = i_step;
      n++;
      hist[n[11:0]] = m_data;
    end
  end

  // Output after edge n shows scan position n-1: 5-cycle slots, first cycle dark, digits 0..3.
  int          k, pos, dg, sstart;
  logic [15:0] sv, upper;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;

  always @(negedge clk) begin
    if (!rst) begin
      check("o_data", o_data, m_data);
      check("o_valid", o_valid, m_valid);
      if (n == 0) begin
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
      end else begin
        k      = n - 1;
        pos    = k % 5;
        dg     = (k / 5) % 4;
        sstart = k - pos;
        sv     = hist[sstart[11:0]];
        upper  = sv >> (4*dg);
        exp_an = (pos == 0) ? 4'hF : ~(4'b0001 << dg);
        exp_seg = (BLANK && dg != 0 && upper == 16'h0) ? 8'hFF : segtab[upper[3:0]];
      end
      check("o_anodes", o_anodes, exp_an);
      check("o_segments", o_segments, exp_seg);
    end
  end

  task automatic adv(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    i_seed = v;
    i_load = 1'b1;
    adv(1);
    i_load = 1'b0;
  endtask

  task automatic capture_digits(output logic [7:0] got [4]);
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    for (int i = 0; i < 20; i++) begin
      adv(1);
      case (o_anodes)
        4'hE: got[0] = o_segments;
        4'hD: got[1] = o_segments;
        4'hB: got[2] = o_segments;
        4'h7: got[3] = o_segments;
        default: ;
      endcase
    end
  endtask

  int          vcount;
  logic [15:0] exp_v;
  logic [7:0]  got [4];

  initial begin
    // Reset, RUN cadence and scan order
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    adv(1);  check("reset_data", o_data, 16'h0001);
             check("reset_anodes", o_anodes, 4'hF);
             check("reset_segs", o_segments, 8'hFF);
    adv(1);  check("scan_n1_dark", o_anodes, 4'hF);
    adv(1);  check("scan_dig0", o_anodes, 4'hE);
    adv(5);  check("scan_dig1", o_anodes, 4'hD);
    adv(3);  check("run_c10", o_data, 16'h0002);
             check("run_c10_valid", o_valid, 1'b1);
    adv(2);  check("scan_dig2", o_anodes, 4'hB);
    adv(5);  check("scan_dig3", o_anodes, 4'h7);
    adv(3);  check("run_c20", o_data, 16'h0004);

    // HOLD freezes the value
    i_mode = 2'b01;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin adv(1); if (o_valid) vcount++; end
    check("hold_valid_count", vcount, 0);
    check("hold_data", o_data, 16'h0004);

    // STEP sequence from 0001
    i_mode = 2'b10;
    load(16'h0001);
    check("step_start", o_data, 16'h0001);
    vcount = 0;
    for (int i = 1; i <= 11; i++) begin
      i_step = 1'b1; adv(1);
      if (o_valid) vcount++;
      exp_v = (i == 11) ? 16'h0801 : 16'(1 << i);
      check("step_seq", o_data, exp_v);
      i_step = 1'b0; adv(1);
      if (o_valid) vcount++;
    end
    check("step_valid_count", vcount, 11);
    vcount = 0;
    i_step = 1'b1;
    for (int i = 0; i < 20; i++) begin adv(1); if (o_valid) vcount++; end
    i_step = 1'b0;
    for (int i = 0; i < 2; i++) begin adv(1); if (o_valid) vcount++; end
    check("held_step_count", vcount, 1);
    check("held_step_data", o_data, 16'h1002);

    // Load zero, then load colliding with a tick
    i_mode = 2'b01;
    load(16'h0000);
    check("load_zero", o_data, 16'h0001);
    for (int i = 0; i < 20 && (m_since % 10) != 9; i++) adv(1);
    i_mode = 2'b00;
    load(16'hBEEF);
    check("load_beats_tick", o_data, 16'hBEEF);
    check("load_valid", o_valid, 1'b1);
    adv(9);  check("tick_not_early", o_data, 16'hBEEF);
    adv(1);  check("tick_after_load", o_data, 16'h7DDE);
             check("tick_after_load_valid", o_valid, 1'b1);
    i_mode = 2'b01;

    // Segment decode and blanking
    load(16'h89AF);
    adv(10);
    capture_digits(got);
    check("seg_dig0", got[0], 8'h8E);
    check("seg_dig1", got[1], 8'h88);
    check("seg_dig2", got[2], 8'h90);
    check("seg_dig3", got[3], 8'h80);
    load(16'h0030);
    adv(10);
    capture_digits(got);
    check("blank_dig0", got[0], 8'hC0);
    check("blank_dig1", got[1], 8'hB0);
    check("blank_dig2", got[2], BLANK ? 8'hFF : 8'hC0);
    check("blank_dig3", got[3], BLANK ? 8'hFF : 8'hC0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) i_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) i_step = ~i_step;
      i_load = ($urandom_range(0, 49) == 0);
      i_seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      adv(1);
    end
    i_load = 1'b0;

    // Asynchronous reset in the middle of a digit slot
    for (int i = 0; i < 10 && (n % 5) != 2; i++) adv(1);
    @(posedge clk); #2 rst = 1'b1;
    #1 check("async_rst_anodes", o_anodes, 4'hF);
       check("async_rst_segs", o_segments, 8'hFF);
    @(posedge clk); #3 rst = 1'b0;
    i_mode = 2'b01;
    adv(1);  check("rerst_data", o_data, 16'h0001);
    adv(2);  check("rerst_dig0", o_anodes, 4'hE);
    adv(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
